// File: rtl/sa_ram_pkg.sv
// Shared definitions for the 256x256 SA RAM read path: geometry, read latency,
// and the read-streamer FSM state encoding.
package sa_ram_pkg;

  localparam int unsigned SA_AW     = 8;
  localparam int unsigned SA_DW     = 256;
  localparam int unsigned SA_RD_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sa_ram_rd_skid_fifo.sv
// Small synchronous FIFO holding returned RAM beats (data + last tag) with an
// occupancy count; push and pop may happen in the same cycle.
module sa_ram_rd_skid_fifo #(
  parameter int unsigned DEP = 2,
  parameter int unsigned W   = 257
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEP+1)-1:0]   o_occ
);

  localparam int unsigned OW = $clog2(DEP + 1);
  localparam int unsigned PW = (DEP > 1) ? $clog2(DEP) : 1;

  logic [W-1:0]  r_mem [DEP];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [OW-1:0] r_occ;
  logic          w_do_pop;
  logic          w_full;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEP - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop = i_pop && (r_occ != '0);
  assign w_full   = (r_occ == OW'(DEP));

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= f_inc(r_wptr);
      end
      if (w_do_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      case ({i_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rptr];
  assign o_occ  = r_occ;

  // The issuer guarantees buffered + in-flight never exceeds DEP.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule

// File: rtl/sa_ram_rd_streamer_256x256.sv
// Read-side burst master for the 256x256 SA RAM: issues one read per cycle when
// the output buffer has room and streams returned beats out with a last flag.
module sa_ram_rd_streamer_256x256
  import sa_ram_pkg::*;
#(
  parameter int unsigned AW       = SA_AW,
  parameter int unsigned DW       = SA_DW,
  parameter int unsigned SKID_DEP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_vld,
  output logic          cmd_rdy,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic          dat_vld,
  input  logic          dat_rdy,
  output logic [DW-1:0] dat_pd,
  output logic          dat_last,
  output logic          busy
);

  localparam int unsigned OW = $clog2(SKID_DEP + 1);
  localparam int unsigned LW = OW + 1;

  rd_state_e     r_state;
  rd_state_e     w_state_nxt;
  logic [AW-1:0] r_cur_addr;
  logic [AW-1:0] r_rem;
  logic          r_pend;
  logic          r_pend_last;

  logic [OW-1:0] w_occ;
  logic [DW:0]   w_head;
  logic [LW-1:0] w_level;
  logic          w_pop;
  logic          w_issue;
  logic          w_final;
  logic          w_accept;

  assign w_accept = cmd_vld && cmd_rdy;
  assign w_pop    = dat_vld && dat_rdy;

  // Room check counts the beat leaving this cycle so a full-rate stream never bubbles.
  assign w_level = LW'(w_occ) + LW'(r_pend) - LW'(w_pop);
  assign w_issue = (r_state == RUN) && (w_level < LW'(SKID_DEP));
  assign w_final = w_issue && (r_rem == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (cmd_vld) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_final) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_pend && (w_occ == OW'(w_pop))) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr  <= '0;
      r_rem       <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_addr <= cmd_addr;
        r_rem      <= cmd_len;
      end else if (w_issue) begin
        r_cur_addr <= r_cur_addr + 1'b1;
        r_rem      <= r_rem - 1'b1;
      end
      r_pend      <= w_issue;
      r_pend_last <= w_final;
    end
  end

  sa_ram_rd_skid_fifo #(
    .DEP (SKID_DEP),
    .W   (DW + 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pend),
    .i_push_data ({r_pend_last, ram_dout}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  assign cmd_rdy  = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign ram_re   = w_issue;
  assign ram_ra   = r_cur_addr;
  assign dat_vld  = (w_occ != '0);
  assign dat_pd   = w_head[DW-1:0];
  assign dat_last = w_head[DW];

endmodule

// File: tb/tb_sa_ram_rd_streamer_256x256.sv
// Bench for sa_ram_rd_streamer_256x256: RAM model preloaded with {32{addr}},
// directed and random bursts checked against a beat-count/timing reference.
module tb_sa_ram_rd_streamer_256x256;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 256;
  localparam int unsigned SKID = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic          dat_vld;
  logic          dat_rdy;
  logic [DW-1:0] dat_pd;
  logic          dat_last;
  logic          busy;

  logic [DW-1:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  sa_ram_rd_streamer_256x256 #(
    .AW       (AW),
    .DW       (DW),
    .SKID_DEP (SKID)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .ram_ra   (ram_ra),
    .ram_re   (ram_re),
    .ram_dout (ram_dout),
    .dat_vld  (dat_vld),
    .dat_rdy  (dat_rdy),
    .dat_pd   (dat_pd),
    .dat_last (dat_last),
    .busy     (busy)
  );

  function automatic logic [DW-1:0] pat(input int unsigned a);
    logic [7:0] b;
    b = a[7:0];
    return {32{b}};
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int unsigned obs, input int unsigned exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready; 1: random ready; 2: ready low for cycles 6..10 after accept.
  // abort_at != 0 stops once that many beats are decided, leaving the DUT mid-burst.
  task automatic run_burst(input int unsigned addr, input int unsigned len,
                           input int mode, input int unsigned abort_at);
    int unsigned   nb;
    int unsigned   issued;
    int unsigned   popped;
    int unsigned   ready_cnt;
    int unsigned   iss_cyc[$];
    int unsigned   budget;
    int unsigned   target;
    logic [DW-1:0] held;
    logic          was_stall;
    logic          seen_vld;
    logic          exp_vld;
    logic          pop;
    logic          exp_re;
    nb        = len + 1;
    issued    = 0;
    popped    = 0;
    budget    = nb * 10 + 60;
    target    = (abort_at != 0) ? abort_at : nb;
    was_stall = 1'b0;
    seen_vld  = 1'b0;
    held      = '0;

    for (int i = 0; i < 20 && !cmd_rdy; i++) step();
    chk_b("cmd_rdy_idle", cmd_rdy, 1'b1);
    cmd_addr = addr[AW-1:0];
    cmd_len  = len[AW-1:0];
    cmd_vld  = 1'b1;
    dat_rdy  = 1'b0;
    step();
    cmd_vld = 1'b0;

    for (int unsigned k = 1; k <= budget; k++) begin
      case (mode)
        1:       dat_rdy = ($urandom_range(0, 3) != 0);
        2:       dat_rdy = !(k >= 6 && k <= 10);
        default: dat_rdy = 1'b1;
      endcase
      @(negedge clk);
      ready_cnt = 0;
      foreach (iss_cyc[j]) if (iss_cyc[j] + 2 <= k) ready_cnt++;
      exp_vld = (ready_cnt > popped);
      chk_b("dat_vld", dat_vld, exp_vld);
      chk_b("busy_active", busy, 1'b1);
      chk_b("cmd_rdy_active", cmd_rdy, 1'b0);
      pop    = exp_vld && dat_rdy;
      exp_re = (issued < nb) && ((issued - popped - (pop ? 1 : 0)) < SKID);
      chk_b("ram_re", ram_re, exp_re);
      if (exp_re) begin
        chk_i("ram_ra", int'(ram_ra), (addr + issued) % 256);
        iss_cyc.push_back(k);
        issued++;
      end
      if (mode == 0 && exp_vld && !seen_vld) begin
        chk_i("first_beat_latency", k, 3);
        seen_vld = 1'b1;
      end
      if (was_stall) chk_d("pd_stable", dat_pd, held);
      if (pop) begin
        chk_d("dat_pd", dat_pd, pat(addr + popped));
        chk_b("dat_last", dat_last, popped == nb - 1);
        popped++;
      end
      was_stall = exp_vld && !dat_rdy;
      held      = dat_pd;
      if (popped == target) break;
      step();
    end
    chk_i("beats_delivered", popped, target);

    if (abort_at == 0) begin
      step();
      dat_rdy = 1'b0;
      @(negedge clk);
      chk_b("busy_done", busy, 1'b0);
      chk_b("cmd_rdy_done", cmd_rdy, 1'b1);
      chk_b("dat_vld_done", dat_vld, 1'b0);
      chk_b("ram_re_done", ram_re, 1'b0);
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    rst      = 1'b1;
    cmd_vld  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    dat_rdy  = 1'b0;
    ram_dout = '0;

    #1;
    chk_b("rst_dat_vld", dat_vld, 1'b0);
    chk_b("rst_dat_last", dat_last, 1'b0);
    chk_b("rst_ram_re", ram_re, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_b("rst_rel_cmd_rdy", cmd_rdy, 1'b1);
    chk_b("rst_rel_dat_vld", dat_vld, 1'b0);
    step();

    run_burst(32'h10, 0, 0, 0);
    run_burst(32'h20, 3, 0, 0);
    run_burst(32'hFE, 3, 0, 0);
    run_burst(32'h30, 15, 2, 0);
    run_burst(32'h00, 255, 0, 0);
    for (int r = 0; r < 4; r++) begin
      run_burst($urandom_range(0, 255), $urandom_range(0, 40), 1, 0);
    end

    // Reset mid-burst at beat 5, then a short burst must come out clean.
    run_burst(32'h80, 15, 0, 5);
    #1;
    rst = 1'b1;
    #1;
    chk_b("midrst_dat_vld", dat_vld, 1'b0);
    chk_b("midrst_ram_re", ram_re, 1'b0);
    chk_b("midrst_busy", busy, 1'b0);
    dat_rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_b("postrst_dat_vld", dat_vld, 1'b0);
      chk_b("postrst_cmd_rdy", cmd_rdy, 1'b1);
      step();
    end
    run_burst(32'h40, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
